// File: rtl/jk_pkg.sv
// jk_pkg: shared types and helpers for the JK bank arbiter.
//   jk_op_e   : per-bit command; the encoding is the {J,K} drive pair.
//   jk_decode : op -> {j,k}.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_e;

  function automatic logic [1:0] jk_decode(input jk_op_e op);
    logic [1:0] jk;
    case (op)
      JK_CLR:  jk = 2'b01;
      JK_SET:  jk = 2'b10;
      JK_TOG:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop, async active-high reset to 0.
//   clk, rst : clock, async reset
//   j, k     : JK drive (00 hold, 01 clear, 10 set, 11 toggle)
//   q        : state
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter + two-stage sequencer driving a bank
// of WIDTH JK cells from NREQ requesters.
//   clk, rst             : clock, async active-high reset
//   req_valid/req_ready  : per-requester handshake (ready is one-hot or zero)
//   req_op, req_idx      : per-requester command and target bit
//   q                    : bank state
//   ack_valid/id/err     : one-cycle completion pulse, aligned with q update
// Accept at edge N registers J/K vectors; the bank and ack update at N+1.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][1:0]       req_op,
  input  logic [NREQ-1:0][IDXW-1:0]  req_idx,
  output logic [WIDTH-1:0]           q,
  output logic                       ack_valid,
  output logic [IDW-1:0]             ack_id,
  output logic                       ack_err
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [IDW-1:0]   id;
    logic             err;
  } s1_t;

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    cand;
  logic              found;
  logic [STAGES-1:0] vld_pipe;   // [0] stage-1 command held, [1] ack pulse
  logic [1:0]        jk;
  logic              err_in;
  logic [WIDTH-1:0]  sel;
  s1_t               s1_d;
  s1_t               s1_q;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  // Forced idle during reset so nothing is granted while rst is high.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (rst) found = 1'b0;
  end

  assign req_ready = found ? (NREQ'(1) << win) : '0;

  // Decode the winner into one-hot J/K vectors. An out-of-range index
  // yields all-zero drive, so the bank holds and only the ack reports it.
  // With no grant the stage register loads zeros, so cells never need a
  // separate enable.
  always_comb begin
    jk     = jk_decode(jk_op_e'(req_op[win]));
    err_in = (int'(req_idx[win]) >= WIDTH);
    sel    = '0;
    if (!err_in) sel = WIDTH'(1) << req_idx[win];
    s1_d.j   = {WIDTH{jk[1]}} & sel;
    s1_d.k   = {WIDTH{jk[0]}} & sel;
    s1_d.id  = win;
    s1_d.err = err_in;
    if (!found) s1_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      vld_pipe <= '0;
      s1_q     <= '0;
      ack_id   <= '0;
      ack_err  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], found};
      s1_q     <= s1_d;
      if (found) rr_ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      if (vld_pipe[0]) ack_id <= s1_q.id;
      ack_err  <= vld_pipe[0] & s1_q.err;
    end
  end

  assign ack_valid = vld_pipe[1];

  // Bank: every cell sees the registered drive; untargeted cells get 00.
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (s1_q.j[g]),
      .k   (s1_q.k[g]),
      .q   (q[g])
    );
  end

endmodule
